// File: rtl/branch_redirect_ctrl.sv
// +--------------------------------------------------------------------------+
// | branch_redirect_ctrl                                                     |
// | Decode-stage branch/jump resolution, delay-slot hold and fetch redirect. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_redirect_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_type,
  input  logic [2:0]       br_cond,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [2:0]       bjpc_con,
  input  logic [31:0]      bjpc_out,
  input  logic             ds_valid,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             fe_ready,
  output logic             br_taken,
  input  logic             exc_flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DS = 2'd1,
    S_REDIR   = 2'd2
  } state_t;

  localparam logic [1:0] C_TYPE_J  = 2'd0;
  localparam logic [1:0] C_TYPE_B  = 2'd1;
  localparam logic [1:0] C_TYPE_JR = 2'd2;

  state_t r_state;
  state_t w_next;

  logic w_rs_zero;
  logic w_rs_neg;
  logic w_cond_true;
  logic w_taken;
  logic w_acc;
  logic w_take_acc;

  assign w_rs_zero = (rs_val == 32'd0);
  assign w_rs_neg  = rs_val[31];

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      3'd0:    w_cond_true = (rs_val == rt_val);
      3'd1:    w_cond_true = (rs_val != rt_val);
      3'd2:    w_cond_true = ~w_rs_neg;
      3'd3:    w_cond_true = ~w_rs_neg & ~w_rs_zero;
      3'd4:    w_cond_true = w_rs_neg | w_rs_zero;
      3'd5:    w_cond_true = w_rs_neg;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_type)
      C_TYPE_J:  w_taken = 1'b1;
      C_TYPE_B:  w_taken = w_cond_true;
      C_TYPE_JR: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  assign br_ready   = (r_state == S_IDLE);
  assign w_acc      = br_valid & br_ready & (br_type != 2'd3) & ~exc_flush;
  assign w_take_acc = w_acc & w_taken;

  // Target-select follows the presented type even when the branch is not
  // accepted (flush), so the mux output is always meaningful in IDLE.
  always_comb begin
    bjpc_con = 3'b000;
    if (br_valid && (r_state == S_IDLE)) begin
      case (br_type)
        C_TYPE_J:  bjpc_con = 3'b001;
        C_TYPE_B:  bjpc_con = 3'b010;
        C_TYPE_JR: bjpc_con = 3'b100;
        default:   bjpc_con = 3'b000;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    if (exc_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_take_acc) w_next = S_WAIT_DS;
        S_WAIT_DS: if (ds_valid)   w_next = S_REDIR;
        S_REDIR:   if (fe_ready)   w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      redirect_valid <= 1'b0;
    end else begin
      r_state        <= w_next;
      redirect_valid <= (w_next == S_REDIR);
    end
  end

  // redirect_pc is only written on a taken accept, so it stays stable
  // through WAIT_DS/REDIR and survives a flush untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc <= 32'd0;
      br_taken    <= 1'b0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      br_taken <= w_take_acc;
      if (w_take_acc) begin
        redirect_pc <= bjpc_out;
        taken_cnt   <= taken_cnt + CNT_W'(1);
      end
      if (w_acc) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// Randomised and directed bench for branch_redirect_ctrl against a
// behavioural model; a second instance with CNT_W=4 checks counter wrap.
`default_nettype none

module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'd3;
  logic [2:0]  br_cond = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [31:0] bjpc_out = 32'd0;
  logic        ds_valid = 1'b0;
  logic        fe_ready = 1'b0;
  logic        exc_flush = 1'b0;

  logic        br_ready, br_ready4;
  logic [2:0]  bjpc_con, bjpc_con4;
  logic        redirect_valid, redirect_valid4;
  logic [31:0] redirect_pc, redirect_pc4;
  logic        br_taken, br_taken4;
  logic [31:0] br_cnt, taken_cnt;
  logic [3:0]  br_cnt4, taken_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_type(br_type), .br_cond(br_cond), .rs_val(rs_val), .rt_val(rt_val),
    .bjpc_con(bjpc_con), .bjpc_out(bjpc_out), .ds_valid(ds_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fe_ready(fe_ready), .br_taken(br_taken), .exc_flush(exc_flush),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_redirect_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready4),
    .br_type(br_type), .br_cond(br_cond), .rs_val(rs_val), .rt_val(rt_val),
    .bjpc_con(bjpc_con4), .bjpc_out(bjpc_out), .ds_valid(ds_valid),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .fe_ready(fe_ready), .br_taken(br_taken4), .exc_flush(exc_flush),
    .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
  );

  // Model: phase 0 = free, 1 = waiting for delay slot, 2 = redirect pending.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_tcnt = 32'd0;
  logic        m_pulse = 1'b0;

  function automatic bit model_taken(input logic [1:0] t, input logic [2:0] c,
                                     input logic [31:0] rs, input logic [31:0] rt);
    int signed s;
    s = $signed(rs);
    if (t == 2'd0 || t == 2'd2) return 1'b1;
    if (t != 2'd1) return 1'b0;
    case (c)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return s >= 0;
      3'd3: return s > 0;
      3'd4: return s <= 0;
      3'd5: return s < 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_pc = 32'd0; m_cnt = 32'd0; m_tcnt = 32'd0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (exc_flush) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (br_valid && br_type != 2'd3) begin
          m_cnt = m_cnt + 1;
          if (model_taken(br_type, br_cond, rs_val, rt_val)) begin
            m_tcnt = m_tcnt + 1; m_pc = bjpc_out; m_pulse = 1'b1; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (ds_valid) m_phase = 2;
      end else begin
        if (fe_ready) m_phase = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e_con;
    e_con = 3'b000;
    if (br_valid && m_phase == 0)
      e_con = (br_type == 2'd0) ? 3'b001 : (br_type == 2'd1) ? 3'b010 :
              (br_type == 2'd2) ? 3'b100 : 3'b000;
    chk("br_ready", br_ready, m_phase == 0);
    chk("bjpc_con", bjpc_con, e_con);
    chk("redirect_valid", redirect_valid, m_phase == 2);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("br_taken", br_taken, m_pulse);
    chk("br_cnt", br_cnt, m_cnt);
    chk("taken_cnt", taken_cnt, m_tcnt);
    chk("br_cnt4", br_cnt4, m_cnt[3:0]);
    chk("taken_cnt4", taken_cnt4, m_tcnt[3:0]);
    chk("redirect_valid4", redirect_valid4, m_phase == 2);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid = 1'b0; br_type = 2'd3; br_cond = 3'd0; rs_val = 32'd0;
    rt_val = 32'd0; ds_valid = 1'b0; fe_ready = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic run_j(input logic [31:0] tgt);
    br_valid = 1'b1; br_type = 2'd0; bjpc_out = tgt;
    cyc();
    br_valid = 1'b0; ds_valid = 1'b1;
    cyc();
    ds_valid = 1'b0; fe_ready = 1'b1;
    cyc();
    fe_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_ready", br_ready, 1'b1);
    chk("reset_rv", redirect_valid, 1'b0);
    chk("reset_cnt", br_cnt, 32'd0);

    // J with delayed delay slot and stalled fetch
    br_valid = 1'b1; br_type = 2'd0; bjpc_out = 32'h1FC0_0100;
    #1 chk("j_con", bjpc_con, 3'b001);
    cyc();
    br_valid = 1'b0; bjpc_out = 32'h0;
    chk("j_taken_pulse", br_taken, 1'b1);
    chk("j_not_ready", br_ready, 1'b0);
    cyc();
    chk("j_pulse_once", br_taken, 1'b0);
    ds_valid = 1'b1;
    cyc();
    ds_valid = 1'b0;
    chk("j_rv", redirect_valid, 1'b1);
    chk("j_pc", redirect_pc, 32'h1FC0_0100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("j_rv_hold", redirect_valid, 1'b1);
      chk("j_pc_hold", redirect_pc, 32'h1FC0_0100);
    end
    fe_ready = 1'b1;
    cyc();
    fe_ready = 1'b0;
    chk("j_rv_done", redirect_valid, 1'b0);
    chk("j_ready_done", br_ready, 1'b1);
    chk("j_br_cnt", br_cnt, 32'd1);
    chk("j_taken_cnt", taken_cnt, 32'd1);

    // Async reset in the middle of a pending redirect
    br_valid = 1'b1; br_type = 2'd2; bjpc_out = 32'h0000_4000;
    cyc();
    br_valid = 1'b0; ds_valid = 1'b1;
    cyc();
    ds_valid = 1'b0;
    chk("pre_rst_rv", redirect_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_ready", br_ready, 1'b1);
    chk("rst_cnt", br_cnt, 32'd0);
    chk("rst_tcnt", taken_cnt, 32'd0);
    cyc();
    rst = 1'b0;

    // BGTZ rs=0 not taken; BGTZ negative not taken; BLEZ -1 taken
    do_reset();
    br_valid = 1'b1; br_type = 2'd1; br_cond = 3'd3; rs_val = 32'd0;
    #1 chk("bgtz_con", bjpc_con, 3'b010);
    cyc();
    chk("bgtz0_ready", br_ready, 1'b1);
    chk("bgtz0_pulse", br_taken, 1'b0);
    chk("bgtz0_cnt", br_cnt, 32'd1);
    chk("bgtz0_tcnt", taken_cnt, 32'd0);
    rs_val = 32'h8000_0000;
    cyc();
    chk("bgtz_neg_tcnt", taken_cnt, 32'd0);
    br_cond = 3'd4; rs_val = 32'hFFFF_FFFF; bjpc_out = 32'hBFC0_0000;
    cyc();
    br_valid = 1'b0;
    chk("blez_pulse", br_taken, 1'b1);
    chk("blez_tcnt", taken_cnt, 32'd1);
    chk("blez_cnt", br_cnt, 32'd3);
    ds_valid = 1'b1; fe_ready = 1'b1;
    cyc();
    ds_valid = 1'b0;
    cyc();
    fe_ready = 1'b0;

    // BEQ taken, flushed while waiting for the delay slot
    do_reset();
    br_valid = 1'b1; br_type = 2'd1; br_cond = 3'd0;
    rs_val = 32'h1234; rt_val = 32'h1234; bjpc_out = 32'h0000_0800;
    cyc();
    br_valid = 1'b0;
    exc_flush = 1'b1;
    cyc();
    exc_flush = 1'b0;
    chk("flush_ready", br_ready, 1'b1);
    ds_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_rv", redirect_valid, 1'b0);
    end
    ds_valid = 1'b0;
    chk("flush_pc_kept", redirect_pc, 32'h0000_0800);

    // JR presented together with a flush is not accepted
    br_valid = 1'b1; br_type = 2'd2; rs_val = 32'h8000_0180;
    bjpc_out = 32'h8000_0180; exc_flush = 1'b1;
    cyc();
    br_valid = 1'b0; exc_flush = 1'b0;
    chk("jr_flush_pulse", br_taken, 1'b0);
    chk("jr_flush_cnt", br_cnt, 32'd1);
    chk("jr_flush_tcnt", taken_cnt, 32'd1);

    // 17 taken J branches wrap the 4-bit counters to 1
    do_reset();
    for (int i = 0; i < 17; i++) run_j(32'h100 + 32'(i) * 4);
    chk("wrap_br_cnt4", br_cnt4, 4'd1);
    chk("wrap_taken_cnt4", taken_cnt4, 4'd1);
    chk("wrap_br_cnt32", br_cnt, 32'd17);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      br_valid  = ($urandom_range(0, 99) < 60);
      br_type   = 2'($urandom_range(0, 3));
      br_cond   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rs_val = 32'd0;
        1: rs_val = 32'h8000_0000 | $urandom;
        default: rs_val = $urandom;
      endcase
      rt_val    = ($urandom_range(0, 2) == 0) ? rs_val : $urandom;
      bjpc_out  = $urandom;
      ds_valid  = ($urandom_range(0, 99) < 40);
      fe_ready  = ($urandom_range(0, 99) < 50);
      exc_flush = ($urandom_range(0, 99) < 4);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
